// File: rtl/mfi_retire_buffer.sv
// mfi_retire_buffer: in-order retirement buffer feeding the per-instruction
// formal checker. Issue-time fields are captured at allocation, completion-time
// fields arrive by tag in any order, and records leave strictly in program
// order on the mfi_* bus, one per cycle at most.
//
// Handshakes: an issue transfers on a cycle where iss_valid && iss_ready, and
// the accepted entry is the one named by iss_tag in that same cycle. A
// completion has no ready; it is consumed whenever cmp_valid is high, and any
// completion that does not name an allocated, not-yet-done entry is dropped
// and raises the sticky err flag. mfi_valid is a one-cycle strobe with no
// back-pressure.
module mfi_retire_buffer #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = $clog2(DEPTH),
  parameter int CHECK_ORDER = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             iss_valid,
  output logic             iss_ready,
  output logic [TAG_W-1:0] iss_tag,
  input  logic [31:0]      iss_inst,
  input  logic [31:0]      iss_pc_rdata,
  input  logic [31:0]      iss_mcr_rdata,
  input  logic [3:0]       iss_src1_addr,
  input  logic [3:0]       iss_src2_addr,
  input  logic [3:0]       iss_src3_addr,
  input  logic [31:0]      iss_src1_rdata,
  input  logic [31:0]      iss_src2_rdata,
  input  logic [31:0]      iss_src3_rdata,
  input  logic             cmp_valid,
  input  logic [TAG_W-1:0] cmp_tag,
  input  logic             cmp_trap,
  input  logic             cmp_halt,
  input  logic             cmp_intr,
  input  logic [3:0]       cmp_dest_addr,
  input  logic [31:0]      cmp_dest_wdata,
  input  logic [31:0]      cmp_pc_wdata,
  input  logic [31:0]      cmp_mcr_wdata,
  input  logic [31:0]      cmp_mem_addr,
  input  logic [31:0]      cmp_mem_rdata,
  input  logic [31:0]      cmp_mem_wdata,
  input  logic [3:0]       cmp_mem_rmask,
  input  logic [3:0]       cmp_mem_wmask,
  output logic             mfi_valid,
  output logic [31:0]      mfi_inst,
  output logic             mfi_trap,
  output logic             mfi_halt,
  output logic             mfi_intr,
  output logic [3:0]       mfi_src1_addr,
  output logic [31:0]      mfi_src1_rdata,
  output logic [3:0]       mfi_src2_addr,
  output logic [31:0]      mfi_src2_rdata,
  output logic [3:0]       mfi_src3_addr,
  output logic [31:0]      mfi_src3_rdata,
  output logic [3:0]       mfi_dest_addr,
  output logic [31:0]      mfi_dest_wdata,
  output logic [31:0]      mfi_pc_rdata,
  output logic [31:0]      mfi_pc_wdata,
  output logic [31:0]      mfi_mcr_rdata,
  output logic [31:0]      mfi_mcr_wdata,
  output logic [31:0]      mfi_mem_addr,
  output logic [3:0]       mfi_mem_rmask,
  output logic [3:0]       mfi_mem_wmask,
  output logic [31:0]      mfi_mem_rdata,
  output logic [31:0]      mfi_mem_wdata,
  output logic [31:0]      mfi_order,
  output logic             check,
  output logic             halted,
  output logic             err
);

  localparam logic [TAG_W:0] PTR_ONE     = {{TAG_W{1'b0}}, 1'b1};
  localparam logic [31:0]    CHECK_ORD_V = CHECK_ORDER;

  typedef struct packed {
    logic [31:0] inst;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [3:0]  src1_addr;
    logic [31:0] src1_rdata;
    logic [3:0]  src2_addr;
    logic [31:0] src2_rdata;
    logic [3:0]  src3_addr;
    logic [31:0] src3_rdata;
    logic [3:0]  dest_addr;
    logic [31:0] dest_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mcr_rdata;
    logic [31:0] mcr_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rec_t;

  rec_t             ent_q [DEPTH];
  rec_t             ent_d [DEPTH];
  logic [DEPTH-1:0] alloc_q, alloc_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [TAG_W:0]   head_q, head_d;
  logic [TAG_W:0]   tail_q, tail_d;
  logic [31:0]      order_q, order_d;
  rec_t             mfi_q, mfi_d;
  logic             mfi_valid_q, mfi_valid_d;
  logic [31:0]      mfi_order_q, mfi_order_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;

  logic [TAG_W:0]   count;
  logic [TAG_W-1:0] head_idx;
  logic             iss_fire;
  logic             cmp_ok;
  logic             retire;

  // Occupancy never exceeds DEPTH, so the count MSB alone marks a full buffer.
  assign count     = tail_q - head_q;
  assign head_idx  = head_q[TAG_W-1:0];
  assign iss_tag   = tail_q[TAG_W-1:0];
  assign iss_ready = reset && !halted_q && !count[TAG_W];
  assign iss_fire  = iss_valid && iss_ready;
  assign cmp_ok    = alloc_q[cmp_tag] && !done_q[cmp_tag] &&
                     !(iss_fire && (cmp_tag == iss_tag));
  assign retire    = alloc_q[head_idx] && done_q[head_idx] && !halted_q;

  // Next-state for entries, pointers, retirement record and status flags.
  always_comb begin
    ent_d       = ent_q;
    alloc_d     = alloc_q;
    done_d      = done_q;
    head_d      = head_q;
    tail_d      = tail_q;
    order_d     = order_q;
    mfi_d       = mfi_q;
    mfi_valid_d = 1'b0;
    mfi_order_d = mfi_order_q;
    halted_d    = halted_q;
    err_d       = err_q;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      alloc_d     = '0;
      done_d      = '0;
      head_d      = '0;
      tail_d      = '0;
      order_d     = '0;
      mfi_d       = '0;
      mfi_order_d = '0;
      halted_d    = 1'b0;
      err_d       = 1'b0;
    end else if (flush) begin
      alloc_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (iss_fire) begin
        ent_d[iss_tag].inst       = iss_inst;
        ent_d[iss_tag].pc_rdata   = iss_pc_rdata;
        ent_d[iss_tag].mcr_rdata  = iss_mcr_rdata;
        ent_d[iss_tag].src1_addr  = iss_src1_addr;
        ent_d[iss_tag].src2_addr  = iss_src2_addr;
        ent_d[iss_tag].src3_addr  = iss_src3_addr;
        ent_d[iss_tag].src1_rdata = iss_src1_rdata;
        ent_d[iss_tag].src2_rdata = iss_src2_rdata;
        ent_d[iss_tag].src3_rdata = iss_src3_rdata;
        alloc_d[iss_tag]          = 1'b1;
        done_d[iss_tag]           = 1'b0;
        tail_d                    = tail_q + PTR_ONE;
      end
      if (cmp_valid) begin
        if (cmp_ok) begin
          ent_d[cmp_tag].trap       = cmp_trap;
          ent_d[cmp_tag].halt       = cmp_halt;
          ent_d[cmp_tag].intr       = cmp_intr;
          ent_d[cmp_tag].dest_addr  = cmp_dest_addr;
          ent_d[cmp_tag].dest_wdata = cmp_dest_wdata;
          ent_d[cmp_tag].pc_wdata   = cmp_pc_wdata;
          ent_d[cmp_tag].mcr_wdata  = cmp_mcr_wdata;
          ent_d[cmp_tag].mem_addr   = cmp_mem_addr;
          ent_d[cmp_tag].mem_rdata  = cmp_mem_rdata;
          ent_d[cmp_tag].mem_wdata  = cmp_mem_wdata;
          ent_d[cmp_tag].mem_rmask  = cmp_mem_rmask;
          ent_d[cmp_tag].mem_wmask  = cmp_mem_wmask;
          done_d[cmp_tag]           = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
      // Head and tail only coincide when empty or full, so the alloc clear
      // here never collides with the alloc set of a same-cycle issue.
      if (retire) begin
        mfi_d             = ent_q[head_idx];
        mfi_valid_d       = 1'b1;
        mfi_order_d       = order_q;
        alloc_d[head_idx] = 1'b0;
        head_d            = head_q + PTR_ONE;
        order_d           = order_q + 32'd1;
        if (ent_q[head_idx].halt) halted_d = 1'b1;
      end
    end
  end

  // State registers; the synchronous reset is folded into the next-state logic.
  always_ff @(posedge clock) begin
    ent_q       <= ent_d;
    alloc_q     <= alloc_d;
    done_q      <= done_d;
    head_q      <= head_d;
    tail_q      <= tail_d;
    order_q     <= order_d;
    mfi_q       <= mfi_d;
    mfi_valid_q <= mfi_valid_d;
    mfi_order_q <= mfi_order_d;
    halted_q    <= halted_d;
    err_q       <= err_d;
  end

  assign mfi_valid      = mfi_valid_q;
  assign mfi_inst       = mfi_q.inst;
  assign mfi_trap       = mfi_q.trap;
  assign mfi_halt       = mfi_q.halt;
  assign mfi_intr       = mfi_q.intr;
  assign mfi_src1_addr  = mfi_q.src1_addr;
  assign mfi_src1_rdata = mfi_q.src1_rdata;
  assign mfi_src2_addr  = mfi_q.src2_addr;
  assign mfi_src2_rdata = mfi_q.src2_rdata;
  assign mfi_src3_addr  = mfi_q.src3_addr;
  assign mfi_src3_rdata = mfi_q.src3_rdata;
  assign mfi_dest_addr  = mfi_q.dest_addr;
  assign mfi_dest_wdata = mfi_q.dest_wdata;
  assign mfi_pc_rdata   = mfi_q.pc_rdata;
  assign mfi_pc_wdata   = mfi_q.pc_wdata;
  assign mfi_mcr_rdata  = mfi_q.mcr_rdata;
  assign mfi_mcr_wdata  = mfi_q.mcr_wdata;
  assign mfi_mem_addr   = mfi_q.mem_addr;
  assign mfi_mem_rmask  = mfi_q.mem_rmask;
  assign mfi_mem_wmask  = mfi_q.mem_wmask;
  assign mfi_mem_rdata  = mfi_q.mem_rdata;
  assign mfi_mem_wdata  = mfi_q.mem_wdata;
  assign mfi_order      = mfi_order_q;
  assign check          = mfi_valid_q && (mfi_order_q == CHECK_ORD_V);
  assign halted         = halted_q;
  assign err            = err_q;

endmodule

// File: tb/tb_mfi_retire_buffer.sv
// Bench for mfi_retire_buffer: drives issues/completions, keeps a small
// program-order model that pushes expected records into a queue, and a
// monitor that pops and compares every record the DUT emits.
module tb_mfi_retire_buffer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 2;
  localparam int RW    = 411;

  typedef struct packed {
    logic [31:0] inst;
    logic        trap;
    logic        halt;
    logic        intr;
    logic [3:0]  src1_addr;
    logic [31:0] src1_rdata;
    logic [3:0]  src2_addr;
    logic [31:0] src2_rdata;
    logic [3:0]  src3_addr;
    logic [31:0] src3_rdata;
    logic [3:0]  dest_addr;
    logic [31:0] dest_wdata;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [31:0] mcr_rdata;
    logic [31:0] mcr_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rec_t;

  logic clock, reset, flush;
  logic iss_valid, iss_ready;
  logic [TAG_W-1:0] iss_tag;
  logic [31:0] iss_inst, iss_pc_rdata, iss_mcr_rdata;
  logic [3:0]  iss_src1_addr, iss_src2_addr, iss_src3_addr;
  logic [31:0] iss_src1_rdata, iss_src2_rdata, iss_src3_rdata;
  logic cmp_valid;
  logic [TAG_W-1:0] cmp_tag;
  logic cmp_trap, cmp_halt, cmp_intr;
  logic [3:0]  cmp_dest_addr;
  logic [31:0] cmp_dest_wdata, cmp_pc_wdata, cmp_mcr_wdata;
  logic [31:0] cmp_mem_addr, cmp_mem_rdata, cmp_mem_wdata;
  logic [3:0]  cmp_mem_rmask, cmp_mem_wmask;
  logic mfi_valid;
  logic [31:0] mfi_inst;
  logic mfi_trap, mfi_halt, mfi_intr;
  logic [3:0]  mfi_src1_addr, mfi_src2_addr, mfi_src3_addr, mfi_dest_addr;
  logic [31:0] mfi_src1_rdata, mfi_src2_rdata, mfi_src3_rdata, mfi_dest_wdata;
  logic [31:0] mfi_pc_rdata, mfi_pc_wdata, mfi_mcr_rdata, mfi_mcr_wdata;
  logic [31:0] mfi_mem_addr, mfi_mem_rdata, mfi_mem_wdata;
  logic [3:0]  mfi_mem_rmask, mfi_mem_wmask;
  logic [31:0] mfi_order;
  logic check, halted, err;

  mfi_retire_buffer #(.DEPTH(DEPTH), .CHECK_ORDER(0)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .iss_inst(iss_inst), .iss_pc_rdata(iss_pc_rdata), .iss_mcr_rdata(iss_mcr_rdata),
    .iss_src1_addr(iss_src1_addr), .iss_src2_addr(iss_src2_addr), .iss_src3_addr(iss_src3_addr),
    .iss_src1_rdata(iss_src1_rdata), .iss_src2_rdata(iss_src2_rdata), .iss_src3_rdata(iss_src3_rdata),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
    .cmp_trap(cmp_trap), .cmp_halt(cmp_halt), .cmp_intr(cmp_intr),
    .cmp_dest_addr(cmp_dest_addr), .cmp_dest_wdata(cmp_dest_wdata),
    .cmp_pc_wdata(cmp_pc_wdata), .cmp_mcr_wdata(cmp_mcr_wdata),
    .cmp_mem_addr(cmp_mem_addr), .cmp_mem_rdata(cmp_mem_rdata), .cmp_mem_wdata(cmp_mem_wdata),
    .cmp_mem_rmask(cmp_mem_rmask), .cmp_mem_wmask(cmp_mem_wmask),
    .mfi_valid(mfi_valid), .mfi_inst(mfi_inst),
    .mfi_trap(mfi_trap), .mfi_halt(mfi_halt), .mfi_intr(mfi_intr),
    .mfi_src1_addr(mfi_src1_addr), .mfi_src1_rdata(mfi_src1_rdata),
    .mfi_src2_addr(mfi_src2_addr), .mfi_src2_rdata(mfi_src2_rdata),
    .mfi_src3_addr(mfi_src3_addr), .mfi_src3_rdata(mfi_src3_rdata),
    .mfi_dest_addr(mfi_dest_addr), .mfi_dest_wdata(mfi_dest_wdata),
    .mfi_pc_rdata(mfi_pc_rdata), .mfi_pc_wdata(mfi_pc_wdata),
    .mfi_mcr_rdata(mfi_mcr_rdata), .mfi_mcr_wdata(mfi_mcr_wdata),
    .mfi_mem_addr(mfi_mem_addr), .mfi_mem_rmask(mfi_mem_rmask), .mfi_mem_wmask(mfi_mem_wmask),
    .mfi_mem_rdata(mfi_mem_rdata), .mfi_mem_wdata(mfi_mem_wdata),
    .mfi_order(mfi_order), .check(check), .halted(halted), .err(err)
  );

  rec_t dut_rec;
  assign dut_rec = {mfi_inst, mfi_trap, mfi_halt, mfi_intr,
                    mfi_src1_addr, mfi_src1_rdata, mfi_src2_addr, mfi_src2_rdata,
                    mfi_src3_addr, mfi_src3_rdata, mfi_dest_addr, mfi_dest_wdata,
                    mfi_pc_rdata, mfi_pc_wdata, mfi_mcr_rdata, mfi_mcr_wdata,
                    mfi_mem_addr, mfi_mem_rmask, mfi_mem_wmask, mfi_mem_rdata, mfi_mem_wdata};

  // Clock and counters
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model and scoreboard
  logic [RW+31:0] exp_q[$];
  rec_t m_ent [DEPTH];
  bit   m_alloc [DEPTH];
  bit   m_done [DEPTH];
  int   m_head, m_tail, m_order;
  bit   m_halted;

  function automatic void model_reset(input bit keep_status);
    for (int i = 0; i < DEPTH; i++) begin
      m_alloc[i] = 1'b0;
      m_done[i]  = 1'b0;
    end
    m_head = 0;
    m_tail = 0;
    if (!keep_status) begin
      m_order  = 0;
      m_halted = 1'b0;
      exp_q.delete();
    end
  endfunction

  function automatic void model_drain();
    while (!m_halted && m_alloc[m_head % DEPTH] && m_done[m_head % DEPTH]) begin
      int h;
      h = m_head % DEPTH;
      exp_q.push_back({32'(m_order), m_ent[h]});
      if (m_ent[h].halt) m_halted = 1'b1;
      m_alloc[h] = 1'b0;
      m_head++;
      m_order++;
    end
  endfunction

  // Drivers
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_issue(output int tag);
    rec_t r;
    r = '0;
    r.inst       = $urandom;
    r.pc_rdata   = $urandom;
    r.mcr_rdata  = $urandom;
    r.src1_addr  = 4'($urandom_range(0, 15));
    r.src2_addr  = 4'($urandom_range(0, 15));
    r.src3_addr  = 4'($urandom_range(0, 15));
    r.src1_rdata = $urandom;
    r.src2_rdata = $urandom;
    r.src3_rdata = $urandom;
    tag = m_tail % DEPTH;
    check_eq("iss_ready", iss_ready, 1);
    check_eq("iss_tag", iss_tag, tag);
    iss_inst = r.inst; iss_pc_rdata = r.pc_rdata; iss_mcr_rdata = r.mcr_rdata;
    iss_src1_addr = r.src1_addr; iss_src2_addr = r.src2_addr; iss_src3_addr = r.src3_addr;
    iss_src1_rdata = r.src1_rdata; iss_src2_rdata = r.src2_rdata; iss_src3_rdata = r.src3_rdata;
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    m_ent[tag]   = r;
    m_alloc[tag] = 1'b1;
    m_done[tag]  = 1'b0;
    m_tail++;
  endtask

  task automatic do_complete(input int tag, input bit halt);
    logic [31:0] dw, pw, mw, ma, mr, mwd;
    logic [3:0]  da, rm, wm;
    logic        tr, it;
    dw = $urandom; pw = $urandom; mw = $urandom;
    ma = $urandom; mr = $urandom; mwd = $urandom;
    da = 4'($urandom_range(0, 15)); rm = 4'($urandom_range(0, 15)); wm = 4'($urandom_range(0, 15));
    tr = 1'($urandom_range(0, 1)); it = 1'($urandom_range(0, 1));
    cmp_tag = TAG_W'(tag);
    cmp_trap = tr; cmp_halt = halt; cmp_intr = it;
    cmp_dest_addr = da; cmp_dest_wdata = dw; cmp_pc_wdata = pw; cmp_mcr_wdata = mw;
    cmp_mem_addr = ma; cmp_mem_rdata = mr; cmp_mem_wdata = mwd;
    cmp_mem_rmask = rm; cmp_mem_wmask = wm;
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    if (m_alloc[tag] && !m_done[tag]) begin
      m_ent[tag].trap = tr; m_ent[tag].halt = halt; m_ent[tag].intr = it;
      m_ent[tag].dest_addr = da; m_ent[tag].dest_wdata = dw;
      m_ent[tag].pc_wdata = pw; m_ent[tag].mcr_wdata = mw;
      m_ent[tag].mem_addr = ma; m_ent[tag].mem_rdata = mr; m_ent[tag].mem_wdata = mwd;
      m_ent[tag].mem_rmask = rm; m_ent[tag].mem_wmask = wm;
      m_done[tag] = 1'b1;
    end
    model_drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, mfi_valid, 0);
    check_eq({tag, "_rec"}, dut_rec, 0);
    check_eq({tag, "_order"}, mfi_order, 0);
    check_eq({tag, "_check"}, check, 0);
    check_eq({tag, "_halted"}, halted, 0);
    check_eq({tag, "_err"}, err, 0);
    check_eq({tag, "_ready"}, iss_ready, 0);
  endtask

  // Monitor: every emitted record must be the next expected one
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (mfi_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_rec", {mfi_order, dut_rec}, 0);
        end else begin
          logic [RW+31:0] e;
          rec_t er;
          e  = exp_q.pop_front();
          er = e[RW-1:0];
          check_eq("mfi_rec", {mfi_order, dut_rec}, e);
          check_eq("check_pulse", check, (e[RW+31:RW] == 32'd0));
          if (er.halt) check_eq("halted_on_halt", halted, 1);
        end
      end else begin
        check_eq("check_idle", check, 0);
      end
    end
  end

  // Stimulus
  initial begin
    int t0, t1, t2, t3;
    reset = 1'b0; flush = 1'b0; iss_valid = 1'b0; cmp_valid = 1'b0; cmp_tag = '0;
    iss_inst = '0; iss_pc_rdata = '0; iss_mcr_rdata = '0;
    iss_src1_addr = '0; iss_src2_addr = '0; iss_src3_addr = '0;
    iss_src1_rdata = '0; iss_src2_rdata = '0; iss_src3_rdata = '0;
    cmp_trap = 1'b0; cmp_halt = 1'b0; cmp_intr = 1'b0; cmp_dest_addr = '0;
    cmp_dest_wdata = '0; cmp_pc_wdata = '0; cmp_mcr_wdata = '0;
    cmp_mem_addr = '0; cmp_mem_rdata = '0; cmp_mem_wdata = '0;
    cmp_mem_rmask = '0; cmp_mem_wmask = '0;
    model_reset(1'b0);
    tick();
    tick();
    check_reset_outputs("por");
    reset = 1'b1;
    #1;

    // In order, with exact first-record latency
    do_issue(t0); do_issue(t1); do_issue(t2);
    do_complete(t0, 1'b0);
    check_eq("lat_not_early", mfi_valid, 0);
    do_complete(t1, 1'b0);
    check_eq("lat_first", mfi_valid, 1);
    check_eq("lat_order0", mfi_order, 0);
    do_complete(t2, 1'b0);
    repeat (3) tick();

    // Out of order: younger completes first and must wait
    do_issue(t0); do_issue(t1);
    do_complete(t1, 1'b0);
    repeat (3) tick();
    check_eq("ooo_hold", mfi_valid, 0);
    do_complete(t0, 1'b0);
    tick();
    check_eq("ooo_first", {mfi_valid, mfi_order}, {1'b1, 32'd3});
    tick();
    check_eq("ooo_second", {mfi_valid, mfi_order}, {1'b1, 32'd4});
    tick();

    // Full buffer, no same-cycle bypass, tag wrap
    do_issue(t0); do_issue(t1); do_issue(t2); do_issue(t3);
    check_eq("full_ready", iss_ready, 0);
    do_complete(t0, 1'b0);
    check_eq("full_no_bypass", iss_ready, 0);
    tick();
    check_eq("full_ready_again", iss_ready, 1);
    check_eq("wrap_tag", iss_tag, t0);
    do_complete(t1, 1'b0); do_complete(t2, 1'b0); do_complete(t3, 1'b0);
    repeat (3) tick();

    // Double completion keeps first data and raises err
    check_eq("err_clear", err, 0);
    do_issue(t0); do_issue(t1);
    do_complete(t1, 1'b0);
    check_eq("err_after_first", err, 0);
    do_complete(t1, 1'b0);
    check_eq("err_double", err, 1);
    do_complete(t0, 1'b0);
    repeat (4) tick();

    // Reset mid-flight
    do_issue(t0); do_issue(t1);
    do_complete(t1, 1'b0);
    reset = 1'b0;
    tick();
    check_reset_outputs("mid_rst");
    reset = 1'b1;
    model_reset(1'b0);
    #1;
    do_issue(t0);
    check_eq("rst_tag0", t0, 0);
    do_complete(t0, 1'b0);
    tick();
    check_eq("check_again", check, 1);
    tick();

    // Completion of an unallocated tag
    check_eq("err_after_reset", err, 0);
    do_complete(3, 1'b0);
    check_eq("err_unalloc", err, 1);
    repeat (3) tick();
    check_eq("err_sticky", err, 1);

    // Flush with two done entries behind an undone head
    do_issue(t0); do_issue(t1); do_issue(t2);
    do_complete(t1, 1'b0); do_complete(t2, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    model_reset(1'b1);
    check_eq("flush_valid", mfi_valid, 0);
    check_eq("flush_tag", iss_tag, 0);
    check_eq("flush_err_kept", err, 1);
    repeat (3) tick();
    do_issue(t0);
    do_complete(t0, 1'b0);
    tick();
    check_eq("flush_order_kept", {mfi_valid, mfi_order}, {1'b1, 32'd1});
    tick();

    // Halt: later done entries stay put
    do_issue(t0); do_issue(t1);
    do_complete(t1, 1'b0);
    do_complete(t0, 1'b1);
    tick();
    check_eq("halted_set", halted, 1);
    check_eq("halted_ready", iss_ready, 0);
    repeat (5) tick();
    check_eq("halted_sticky", halted, 1);
    check_eq("exp_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
